// File: rtl/polar_pkg.sv
// Shared constants, FSM state type and the phase-wrap helper for the
// polar burst statistics block.
package polar_pkg;

    localparam int MAX_LEN = 1024;
    localparam int MAG_W   = 12;
    localparam int PH_W    = 21;
    localparam int ACC_W   = 32;
    localparam int IDX_W   = 10;
    localparam int CNT_W   = 11;
    localparam int FRQ_W   = 22;

    localparam logic signed [FRQ_W-1:0] PH_ONE = 22'sh100000;
    localparam logic        [FRQ_W-1:0] PH_TWO = 22'h200000;

    typedef enum logic [1:0] {IDLE, ACC, DIV, OUT} state_t;

    // Shortest signed phase step from prev to cur, in [-1.0, +1.0) pi rad.
    function automatic logic signed [FRQ_W-1:0] wrap_step(input logic [PH_W-1:0] cur,
                                                          input logic [PH_W-1:0] prev);
        logic signed [FRQ_W-1:0] d;
        d = $signed({1'b0, cur}) - $signed({1'b0, prev});
        // Adding or subtracting 2.0 gives the same 22-bit result, so one adder covers both wraps.
        if (d >= PH_ONE || d < -PH_ONE) begin
            d = d + PH_TWO;
        end
        return d;
    endfunction

endpackage

// File: rtl/seq_div.sv
// Unsigned restoring divider, one quotient bit per cycle, fixed 32 cycles.
// The first step runs in the start cycle; done and quotient are valid together in the final step cycle.
module seq_div (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [10:0] divisor,
    output logic        done,
    output logic [31:0] quotient
);

    logic [10:0] rem_q;
    logic [31:0] bits_q;
    logic [4:0]  cnt_q;
    logic        active_q;

    logic [10:0] rem_in;
    logic [31:0] bits_in;
    logic [11:0] trial;
    logic [10:0] rem_nx;
    logic [31:0] bits_nx;

    // bits holds the unconsumed dividend bits on the left and quotient bits shifting in on the right.
    always_comb begin
        rem_in  = start ? 11'd0 : rem_q;
        bits_in = start ? dividend : bits_q;
        trial   = {rem_in, bits_in[31]};
        if (trial >= {1'b0, divisor}) begin
            rem_nx  = 11'(trial - {1'b0, divisor});
            bits_nx = {bits_in[30:0], 1'b1};
        end else begin
            rem_nx  = trial[10:0];
            bits_nx = {bits_in[30:0], 1'b0};
        end
    end

    assign done     = active_q && (cnt_q == 5'd31);
    assign quotient = bits_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q    <= '0;
            bits_q   <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else if (start) begin
            rem_q    <= rem_nx;
            bits_q   <= bits_nx;
            cnt_q    <= 5'd1;
            active_q <= 1'b1;
        end else if (active_q) begin
            rem_q  <= rem_nx;
            bits_q <= bits_nx;
            cnt_q  <= cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
                active_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/polar_burst_stats.sv
// Per-burst peak magnitude, peak index, sample count and mean wrapped phase step
// for the CORDIC rectangular-to-polar output stream.
module polar_burst_stats
    import polar_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [MAG_W-1:0] in_mag,
    input  logic [PH_W-1:0]  in_phase,
    output logic             busy,
    output logic             out_valid,
    output logic [MAG_W-1:0] out_peak_mag,
    output logic [IDX_W-1:0] out_peak_idx,
    output logic [CNT_W-1:0] out_count,
    output logic [FRQ_W-1:0] out_freq,
    output state_t           dbg_state
);

    // Handshake: there is no ready; a sample is taken on every rising edge with in_valid high while
    // the block is IDLE or ACC, the first low cycle closes the burst, and out_valid is a one-cycle
    // strobe with the data outputs held until the next strobe.

    localparam logic [ACC_W-1:0] FREQ_MAX = {{(ACC_W-FRQ_W){1'b0}}, PH_ONE};

    state_t state_q, state_d;

    logic [CNT_W-1:0]        count_q;
    logic [MAG_W-1:0]        peak_q;
    logic [IDX_W-1:0]        idx_q;
    logic [PH_W-1:0]         prev_q;
    logic signed [ACC_W-1:0] sum_q;

    logic                    acc_take;
    logic signed [FRQ_W-1:0] step;
    logic                    div_start;
    logic                    div_done;
    logic [ACC_W-1:0]        abs_sum;
    logic [CNT_W-1:0]        divisor;
    logic [ACC_W-1:0]        div_quo;
    logic [FRQ_W-1:0]        freq_mag;
    logic [FRQ_W-1:0]        freq_fix;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = ACC;
            ACC:     if (!in_valid) state_d = DIV;
            DIV:     if (div_done) state_d = OUT;
            OUT:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign acc_take  = (state_q == ACC) && in_valid && (count_q < CNT_W'(MAX_LEN));
    assign step      = wrap_step(in_phase, prev_q);
    assign div_start = (state_q == ACC) && !in_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            peak_q  <= '0;
            idx_q   <= '0;
            prev_q  <= '0;
            sum_q   <= '0;
        end else if (state_q == IDLE && in_valid) begin
            count_q <= CNT_W'(1);
            peak_q  <= in_mag;
            idx_q   <= '0;
            prev_q  <= in_phase;
            sum_q   <= '0;
        end else if (acc_take) begin
            sum_q   <= sum_q + ACC_W'(step);
            prev_q  <= in_phase;
            count_q <= count_q + CNT_W'(1);
            if (in_mag > peak_q) begin
                peak_q <= in_mag;
                idx_q  <= IDX_W'(count_q);
            end
        end
    end

    assign abs_sum = sum_q[ACC_W-1] ? -sum_q : sum_q;
    assign divisor = count_q - CNT_W'(1);

    seq_div u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (abs_sum),
        .divisor  (divisor),
        .done     (div_done),
        .quotient (div_quo)
    );

    // A single-sample burst has no steps, so its divide-by-zero quotient is discarded.
    always_comb begin
        if (count_q == CNT_W'(1)) begin
            freq_mag = '0;
        end else if (div_quo > FREQ_MAX) begin
            freq_mag = PH_ONE;
        end else begin
            freq_mag = div_quo[FRQ_W-1:0];
        end
        freq_fix = sum_q[ACC_W-1] ? -freq_mag : freq_mag;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_peak_mag <= '0;
            out_peak_idx <= '0;
            out_count    <= '0;
            out_freq     <= '0;
        end else begin
            out_valid <= 1'b0;
            if (state_q == DIV && div_done) begin
                out_valid    <= 1'b1;
                out_peak_mag <= peak_q;
                out_peak_idx <= idx_q;
                out_count    <= count_q;
                out_freq     <= freq_fix;
            end
        end
    end

    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

endmodule
